// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: shared definitions for the iterative multiply/divide sequencer.
//   FNC_*        funct3 codes of the RV32M operations (MUL..REMU)
//   FNC7_MULDIV  funct7 that tags an ARI_RTYPE instruction as M-extension
//   op_a_signed  1 when operand A (rs1) is interpreted as signed
//   op_b_signed  1 when operand B (rs2) is interpreted as signed
package muldiv_seq_pkg;

  localparam logic [2:0] FNC_MUL    = 3'b000;
  localparam logic [2:0] FNC_MULH   = 3'b001;
  localparam logic [2:0] FNC_MULHSU = 3'b010;
  localparam logic [2:0] FNC_MULHU  = 3'b011;
  localparam logic [2:0] FNC_DIV    = 3'b100;
  localparam logic [2:0] FNC_DIVU   = 3'b101;
  localparam logic [2:0] FNC_REM    = 3'b110;
  localparam logic [2:0] FNC_REMU   = 3'b111;

  localparam logic [6:0] FNC7_MULDIV = 7'b0000001;

  // MUL only needs the low half, which is identical for signed and unsigned
  // operands; treating it as signed x signed keeps the FIX logic uniform.
  function automatic logic op_a_signed(input logic [2:0] f);
    return (f == FNC_MUL) || (f == FNC_MULH) || (f == FNC_MULHSU) ||
           (f == FNC_DIV) || (f == FNC_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] f);
    return (f == FNC_MUL) || (f == FNC_MULH) || (f == FNC_DIV) || (f == FNC_REM);
  endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// muldiv_addsub: W-bit adder/subtractor, the single arithmetic unit shared by
// the multiply loop, the divide loop and the final sign fix-up.
//   a, b  operands
//   sub   0: y = a + b   1: y = a - b   (carry out is dropped, wraps silently)
//   y     result
module muldiv_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);

  assign y = a + (b ^ {W{sub}}) + {{(W-1){1'b0}}, sub};

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer sitting beside the EX ALU.
// One op at a time: radix-2 shift-add multiply or restoring divide on operand
// magnitudes, then a one-cycle sign fix-up, then the result is held until taken.
//
// Ports
//   clk, rst    clock, synchronous active-high reset
//   req_valid   M-extension op presented by EX
//   req_ready   1 only in IDLE
//   funct       funct3 (MUL..REMU)
//   rs1, rs2    operand A (multiplicand/dividend), operand B (multiplier/divisor)
//   kill        flush: abandon everything, IDLE on the next edge
//   resp_valid  result valid (DONE), held until resp_ready
//   resp_ready  consumer takes the result
//   result      product half / quotient / remainder
//   busy        stall request to EX (CALC, FIX, DONE)
//   dbg_state   current FSM state (0 IDLE, 1 CALC, 2 FIX, 3 DONE)
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where resp_valid && resp_ready. kill
// overrides both, rst overrides kill.
//
// Build option: MULDIV_EARLY_OUT_EN, when defined, lets a multiply leave CALC as
// soon as the remaining multiplier bits are all zero.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      funct,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        funct_q, funct_d;
  logic              neg_q, neg_d;      // final result must be negated
  logic [XLEN-1:0]   opb_q, opb_d;      // |multiplicand| or |divisor|
  logic [2*XLEN-1:0] acc_q, acc_d;      // mul: {hi, lo}; div: {remainder, quotient}
  logic [XLEN-1:0]   result_q, result_d;

  // shared adder
  logic [XLEN:0] add_a, add_b, add_y;
  logic          add_sub;

  muldiv_addsub #(.W(XLEN+1)) u_addsub (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .y   (add_y)
  );

  // request decode
  logic            sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;

  assign sign_a   = op_a_signed(funct) & rs1[XLEN-1];
  assign sign_b   = op_b_signed(funct) & rs2[XLEN-1];
  assign mag_a    = sign_a ? (~rs1 + {{(XLEN-1){1'b0}}, 1'b1}) : rs1;
  assign mag_b    = sign_b ? (~rs2 + {{(XLEN-1){1'b0}}, 1'b1}) : rs2;
  assign div_zero = funct[2] && (rs2 == '0);
  assign div_ovf  = ((funct == FNC_DIV) || (funct == FNC_REM)) &&
                    (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);

  // datapath views of the accumulator
  logic [XLEN-1:0] acc_hi, acc_lo, fix_val;
  logic [XLEN:0]   div_shift;
  logic            sel_hi;

  assign acc_hi    = acc_q[2*XLEN-1:XLEN];
  assign acc_lo    = acc_q[XLEN-1:0];
  assign div_shift = {acc_hi, acc_lo[XLEN-1]};
  // MULH*/REM* deliver the upper word, MUL/DIV* the lower one
  assign sel_hi    = funct_q[2] ? funct_q[1] : (funct_q[1:0] != 2'b00);
  assign fix_val   = sel_hi ? acc_hi : acc_lo;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct_d  = funct_q;
    neg_d    = neg_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = result_q;
    add_a    = '0;
    add_b    = '0;
    add_sub  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          funct_d = funct;
          cnt_d   = '0;
          // remainder takes the dividend's sign, everything else the xor
          neg_d   = (funct[2] && funct[1]) ? sign_a : (sign_a ^ sign_b);
          if (div_zero) begin
            result_d = funct[1] ? rs1 : '1;
            state_d  = ST_DONE;
          end else if (div_ovf) begin
            // quotient is rs1 itself (0x80..0), remainder is zero
            result_d = funct[1] ? '0 : rs1;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_CALC;
            if (funct[2]) begin
              acc_d = {{XLEN{1'b0}}, mag_a};
              opb_d = mag_b;
            end else begin
              acc_d = {{XLEN{1'b0}}, mag_b};
              opb_d = mag_a;
            end
          end
        end
      end

      ST_CALC: begin
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(XLEN-1)) begin
          state_d = ST_FIX;
          cnt_d   = '0;
        end
        if (funct_q[2]) begin
          // restoring divide: trial-subtract the divisor from the shifted remainder
          add_a   = div_shift;
          add_b   = {1'b0, opb_q};
          add_sub = 1'b1;
          if (add_y[XLEN]) begin
            acc_d = {div_shift[XLEN-1:0], acc_lo[XLEN-2:0], 1'b0};
          end else begin
            acc_d = {add_y[XLEN-1:0], acc_lo[XLEN-2:0], 1'b1};
          end
        end else begin
          // shift-add multiply: the carry (bit XLEN) shifts into the top of hi
          add_a = {1'b0, acc_hi};
          add_b = acc_lo[0] ? {1'b0, opb_q} : '0;
          acc_d = {add_y, acc_lo[XLEN-1:1]};
`ifdef MULDIV_EARLY_OUT_EN
          // The low XLEN-cnt bits of lo are the multiplier bits still to be
          // consumed. If all are zero the remaining steps are pure shifts:
          // shift by XLEN-cnt = 1 + ~cnt (XLEN is a power of two).
          if ((acc_lo & ({XLEN{1'b1}} >> cnt_q)) == '0) begin
            acc_d   = (acc_q >> 1) >> (~cnt_q);
            state_d = ST_FIX;
            cnt_d   = '0;
          end
`endif
        end
      end

      ST_FIX: begin
        state_d = ST_DONE;
        if (neg_q) begin
          if (!funct_q[2] && sel_hi) begin
            // high word of -{hi,lo} = ~hi + (lo == 0)
            add_a = {1'b0, ~acc_hi};
            add_b = {{XLEN{1'b0}}, (acc_lo == '0)};
          end else begin
            add_b   = {1'b0, fix_val};
            add_sub = 1'b1;
          end
          result_d = add_y[XLEN-1:0];
        end else begin
          result_d = fix_val;
        end
      end

      ST_DONE: begin
        if (resp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (kill) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      funct_q  <= '0;
      neg_q    <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct_q  <= funct_d;
      neg_q    <= neg_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign resp_valid = (state_q == ST_DONE);
  assign result     = result_q;
  assign dbg_state  = state_q;

endmodule
